// File: rtl/alu_issue_if.sv
// alu_issue_if -- handshake and operand bus for the ALU issue stage.
//
// Signals:
//   in_valid/in_ready      upstream handshake carrying in_instr
//   in_instr               32-bit MIPS instruction word
//   rs_addr/rt_addr        register file read addresses (driven by the stage)
//   rs_data/rt_data        register file read data, same cycle as rs_addr/rt_addr
//   flush                  discard the held entry
//   out_valid/out_ready    downstream handshake for the registered entry
//   alu_a/alu_b/alu_op     registered ALU operands and opcode
//   dst_reg/reg_wr         registered destination register and write enable
//   illegal                registered unsupported-instruction flag
//   issue_cnt              number of entries consumed downstream
//
// Modports: slave is the issue stage, master is the surrounding pipeline.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [4:0]  dst_reg;
  logic        reg_wr;
  logic        illegal;
  logic [31:0] issue_cnt;

  modport slave (
    input  in_valid, in_instr, rs_data, rt_data, flush, out_ready,
    output in_ready, rs_addr, rt_addr, out_valid, alu_a, alu_b, alu_op,
           dst_reg, reg_wr, illegal, issue_cnt
  );

  modport master (
    output in_valid, in_instr, rs_data, rt_data, flush, out_ready,
    input  in_ready, rs_addr, rt_addr, out_valid, alu_a, alu_b, alu_op,
           dst_reg, reg_wr, illegal, issue_cnt
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue -- single-entry MIPS ALU issue stage.
//
// Decodes an instruction together with its register file read data into ALU
// operands, opcode and destination, and holds the result in one output
// register slot with a valid/ready handshake. Also counts consumed entries.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   alu_issue_if.slave (see the interface for the individual signals)
//
// ALU opcodes: 0 zero, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 nor, 7 sltu,
// 8 slt, 9 lui, 10 sll, 11 sra, 12 srl. Shifts take the amount from
// alu_a[4:0] and shift alu_b.
module alu_issue (
  input logic       clk,
  input logic       rst,
  alu_issue_if.slave bus
);

  typedef enum logic [3:0] {
    AluZero = 4'd0,
    AluAdd  = 4'd1,
    AluSub  = 4'd2,
    AluAnd  = 4'd3,
    AluOr   = 4'd4,
    AluXor  = 4'd5,
    AluNor  = 4'd6,
    AluSltu = 4'd7,
    AluSlt  = 4'd8,
    AluLui  = 4'd9,
    AluSll  = 4'd10,
    AluSra  = 4'd11,
    AluSrl  = 4'd12
  } alu_op_e;

  // Primary opcodes
  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0A;
  localparam logic [5:0] OpSltiu   = 6'h0B;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSw      = 6'h2B;

  // SPECIAL function codes
  localparam logic [5:0] FnSll  = 6'h00;
  localparam logic [5:0] FnSrl  = 6'h02;
  localparam logic [5:0] FnSra  = 6'h03;
  localparam logic [5:0] FnSllv = 6'h04;
  localparam logic [5:0] FnSrlv = 6'h06;
  localparam logic [5:0] FnSrav = 6'h07;
  localparam logic [5:0] FnAdd  = 6'h20;
  localparam logic [5:0] FnAddu = 6'h21;
  localparam logic [5:0] FnSub  = 6'h22;
  localparam logic [5:0] FnSubu = 6'h23;
  localparam logic [5:0] FnAnd  = 6'h24;
  localparam logic [5:0] FnOr   = 6'h25;
  localparam logic [5:0] FnXor  = 6'h26;
  localparam logic [5:0] FnNor  = 6'h27;
  localparam logic [5:0] FnSlt  = 6'h2A;
  localparam logic [5:0] FnSltu = 6'h2B;

  // Instruction fields
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [4:0]  rd;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [31:0] sext;
  logic [31:0] zext;

  assign op    = bus.in_instr[31:26];
  assign funct = bus.in_instr[5:0];
  assign shamt = bus.in_instr[10:6];
  assign rd    = bus.in_instr[15:11];
  assign rt    = bus.in_instr[20:16];
  assign imm   = bus.in_instr[15:0];
  assign sext  = {{16{imm[15]}}, imm};
  assign zext  = {16'h0000, imm};

  // Register file read addresses are a straight slice of the instruction.
  assign bus.rs_addr = bus.in_instr[25:21];
  assign bus.rt_addr = bus.in_instr[20:16];

  // Decoded (pre-register) fields
  alu_op_e     dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [4:0]  dec_dst;
  logic        dec_wr;
  logic        dec_illegal;
  logic        dec_wr_final;

  always_comb begin
    dec_op      = AluZero;
    dec_a       = '0;
    dec_b       = '0;
    dec_dst     = '0;
    dec_wr      = 1'b0;
    dec_illegal = 1'b0;

    case (op)
      OpSpecial: begin
        // Common R-type routing; the shift-by-immediate cases override a.
        dec_a   = bus.rs_data;
        dec_b   = bus.rt_data;
        dec_dst = rd;
        dec_wr  = 1'b1;
        case (funct)
          FnAdd, FnAddu: dec_op = AluAdd;
          FnSub, FnSubu: dec_op = AluSub;
          FnAnd:         dec_op = AluAnd;
          FnOr:          dec_op = AluOr;
          FnXor:         dec_op = AluXor;
          FnNor:         dec_op = AluNor;
          FnSlt:         dec_op = AluSlt;
          FnSltu:        dec_op = AluSltu;
          FnSll: begin
            dec_op = AluSll;
            dec_a  = {27'b0, shamt};
          end
          FnSrl: begin
            dec_op = AluSrl;
            dec_a  = {27'b0, shamt};
          end
          FnSra: begin
            dec_op = AluSra;
            dec_a  = {27'b0, shamt};
          end
          FnSllv:        dec_op = AluSll;
          FnSrlv:        dec_op = AluSrl;
          FnSrav:        dec_op = AluSra;
          default: begin
            dec_op      = AluZero;
            dec_a       = '0;
            dec_b       = '0;
            dec_dst     = '0;
            dec_wr      = 1'b0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui, OpLw: begin
        dec_a   = bus.rs_data;
        dec_dst = rt;
        dec_wr  = 1'b1;
        case (op)
          OpAddi, OpAddiu, OpLw: begin
            dec_op = AluAdd;
            dec_b  = sext;
          end
          OpSlti: begin
            dec_op = AluSlt;
            dec_b  = sext;
          end
          OpSltiu: begin
            dec_op = AluSltu;
            dec_b  = sext;
          end
          OpAndi: begin
            dec_op = AluAnd;
            dec_b  = zext;
          end
          OpOri: begin
            dec_op = AluOr;
            dec_b  = zext;
          end
          OpXori: begin
            dec_op = AluXor;
            dec_b  = zext;
          end
          default: begin
            // Only lui remains in this group.
            dec_op = AluLui;
            dec_b  = zext;
          end
        endcase
      end
      OpSw: begin
        // Address generation only; no register writeback.
        dec_op = AluAdd;
        dec_a  = bus.rs_data;
        dec_b  = sext;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Writes to $0 are architecturally discarded, so never request them.
  assign dec_wr_final = dec_wr && (dec_dst != 5'd0);

  // Handshake
  logic        valid_q, valid_d;
  logic        accept;
  logic        consume;
  logic [31:0] alu_a_q;
  logic [31:0] alu_b_q;
  logic [3:0]  alu_op_q;
  logic [4:0]  dst_q;
  logic        reg_wr_q;
  logic        illegal_q;
  logic [31:0] cnt_q, cnt_d;

  assign bus.in_ready = !valid_q || bus.out_ready;

  // Flush wins over both accepting a new entry and consuming the held one.
  assign accept  = bus.in_valid && bus.in_ready && !bus.flush;
  assign consume = valid_q && bus.out_ready && !bus.flush;

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
    if (consume) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      dst_q     <= '0;
      reg_wr_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        alu_a_q   <= dec_a;
        alu_b_q   <= dec_b;
        alu_op_q  <= dec_op;
        dst_q     <= dec_dst;
        reg_wr_q  <= dec_wr_final;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.dst_reg   = dst_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.illegal   = illegal_q;
  assign bus.issue_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: a scoreboard queue holds the expected
// entry for every accepted instruction; the head is compared while it is held.
module tb_alu_issue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_if bus ();

  alu_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    logic        wr;
    logic        ill;
  } vec_t;

  vec_t        vt [16];
  vec_t        sb [$];
  vec_t        cur;
  logic        exp_valid;
  int unsigned exp_cnt;
  int          n_pass;
  int          n_total;
  logic [74:0] got;
  logic [74:0] want;

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rsd,
                              input logic [31:0] rtd, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] dst, input logic wr, input logic ill);
    vec_t v;
    v.instr = instr; v.rsd = rsd; v.rtd = rtd; v.op = op;
    v.a = a; v.b = b; v.dst = dst; v.wr = wr; v.ill = ill;
    return v;
  endfunction

  task automatic init_table();
    vt[0]  = mk(32'h01095020, 32'd5,      32'd7,        4'd1,  32'd5,      32'd7,        5'd10, 1, 0);
    vt[1]  = mk(32'h2002FFFF, 32'd0,      32'd0,        4'd1,  32'd0,      32'hFFFFFFFF, 5'd2,  1, 0);
    vt[2]  = mk(32'h3402FFFF, 32'h12,     32'd0,        4'd4,  32'h12,     32'h0000FFFF, 5'd2,  1, 0);
    vt[3]  = mk(32'h00041940, 32'hDEAD,   32'd1,        4'd10, 32'd5,      32'd1,        5'd3,  1, 0);
    vt[4]  = mk(32'hAC040008, 32'h100,    32'h55,       4'd1,  32'h100,    32'd8,        5'd0,  0, 0);
    vt[5]  = mk(32'hFC000000, 32'd3,      32'd4,        4'd0,  32'd0,      32'd0,        5'd0,  0, 1);
    vt[6]  = mk(32'h00220022, 32'd9,      32'd4,        4'd2,  32'd9,      32'd4,        5'd0,  0, 0);
    vt[7]  = mk(32'h00222807, 32'd3,      32'h80000000, 4'd11, 32'd3,      32'h80000000, 5'd5,  1, 0);
    vt[8]  = mk(32'h3C071234, 32'h77,     32'd0,        4'd9,  32'h77,     32'h00001234, 5'd7,  1, 0);
    vt[9]  = mk(32'h2823FFFE, 32'd1,      32'd0,        4'd8,  32'd1,      32'hFFFFFFFE, 5'd3,  1, 0);
    vt[10] = mk(32'h00000001, 32'd1,      32'd2,        4'd0,  32'd0,      32'd0,        5'd0,  0, 1);
    vt[11] = mk(32'h3003F0F0, 32'hFFFF,   32'd0,        4'd3,  32'hFFFF,   32'h0000F0F0, 5'd3,  1, 0);
    vt[12] = mk(32'h0022202B, 32'd6,      32'd9,        4'd7,  32'd6,      32'd9,        5'd4,  1, 0);
    vt[13] = mk(32'h00221827, 32'hF0,     32'h0F,       4'd6,  32'hF0,     32'h0F,       5'd3,  1, 0);
    vt[14] = mk(32'h000237C2, 32'h1234,   32'hABCD,     4'd12, 32'd31,     32'hABCD,     5'd6,  1, 0);
    vt[15] = mk(32'h8C450010, 32'h2000,   32'd0,        4'd1,  32'h2000,   32'h10,       5'd5,  1, 0);
  endtask

  task automatic drive(input int idx, input logic v, input logic ordy, input logic fl);
    cur              = vt[idx];
    bus.in_valid     = v;
    bus.in_instr     = cur.instr;
    bus.rs_data      = cur.rsd;
    bus.rt_data      = cur.rtd;
    bus.out_ready    = ordy;
    bus.flush        = fl;
  endtask

  // Advance one clock, updating the bench's handshake/scoreboard model from
  // the inputs presented for this edge; returns at the following negedge.
  task automatic tick();
    logic acc;
    acc = bus.in_valid && (!exp_valid || bus.out_ready) && !bus.flush;
    if (rst) begin
      exp_valid = 1'b0;
      exp_cnt   = 0;
      sb.delete();
    end else begin
      if (exp_valid && bus.out_ready && !bus.flush) exp_cnt++;
      if (exp_valid && (bus.flush || bus.out_ready)) void'(sb.pop_front());
      if (bus.flush) begin
        exp_valid = 1'b0;
      end else if (acc) begin
        exp_valid = 1'b1;
        sb.push_back(cur);
      end else if (exp_valid && bus.out_ready) begin
        exp_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid);
    else n_pass++;
    got = {bus.alu_op, bus.alu_a, bus.alu_b, bus.dst_reg, bus.reg_wr, bus.illegal};
    n_total++;
    if (got !== 75'd0) $display("FAIL reset_payload got %h want 0", got);
    else n_pass++;
    n_total++;
    if (bus.issue_cnt !== 32'd0) $display("FAIL reset_cnt got %0d want 0", bus.issue_cnt);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_add();
    drive(0, 1'b1, 1'b1, 1'b0);
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL add_in_ready got %b want 1", bus.in_ready);
    else n_pass++;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1) $display("FAIL add_valid got %b want 1", bus.out_valid);
    else n_pass++;
    got  = {bus.alu_op, bus.alu_a, bus.alu_b, bus.dst_reg, bus.reg_wr, bus.illegal};
    want = {4'd1, 32'd5, 32'd7, 5'd10, 1'b1, 1'b0};
    n_total++;
    if (got !== want) $display("FAIL add_payload got %h want %h", got, want);
    else n_pass++;
    drive(0, 1'b0, 1'b1, 1'b0);
    tick();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL add_drain got %b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.issue_cnt !== 32'd1) $display("FAIL add_cnt got %0d want 1", bus.issue_cnt);
    else n_pass++;
  endtask

  task automatic test_decode();
    for (int i = 0; i < 16; i++) begin
      drive(i, 1'b1, 1'b1, 1'b0);
      #1;
      n_total++;
      if ({bus.rs_addr, bus.rt_addr} !== {cur.instr[25:21], cur.instr[20:16]})
        $display("FAIL dec_addr[%0d] got %h/%h want %h/%h", i, bus.rs_addr, bus.rt_addr,
                 cur.instr[25:21], cur.instr[20:16]);
      else n_pass++;
      tick();
      n_total++;
      if (bus.out_valid !== 1'b1 || !exp_valid) begin
        $display("FAIL dec_valid[%0d] got %b want 1", i, bus.out_valid);
      end else begin
        got  = {bus.alu_op, bus.alu_a, bus.alu_b, bus.dst_reg, bus.reg_wr, bus.illegal};
        want = {sb[0].op, sb[0].a, sb[0].b, sb[0].dst, sb[0].wr, sb[0].ill};
        if (got !== want) $display("FAIL dec_payload[%0d] got %h want %h", i, got, want);
        else n_pass++;
      end
    end
    n_total++;
    if (bus.issue_cnt !== exp_cnt) $display("FAIL dec_cnt got %0d want %0d", bus.issue_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_stall();
    drive(0, 1'b1, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(3, 1'b1, 1'b0, 1'b0);
      #1;
      n_total++;
      if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d] got %b want 0", k, bus.in_ready);
      else n_pass++;
      tick();
      got = {bus.alu_op, bus.alu_a, bus.alu_b, bus.dst_reg, bus.reg_wr, bus.illegal};
      want = {vt[0].op, vt[0].a, vt[0].b, vt[0].dst, vt[0].wr, vt[0].ill};
      n_total++;
      if (bus.out_valid !== 1'b1 || got !== want || bus.issue_cnt !== exp_cnt)
        $display("FAIL stall_hold[%0d] got v=%b %h cnt=%0d want v=1 %h cnt=%0d", k,
                 bus.out_valid, got, bus.issue_cnt, want, exp_cnt);
      else n_pass++;
    end
    drive(3, 1'b1, 1'b1, 1'b0);
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1) $display("FAIL stall_release_ready got %b want 1", bus.in_ready);
    else n_pass++;
    tick();
    got  = {bus.alu_op, bus.alu_a, bus.alu_b, bus.dst_reg, bus.reg_wr, bus.illegal};
    want = {sb[0].op, sb[0].a, sb[0].b, sb[0].dst, sb[0].wr, sb[0].ill};
    n_total++;
    if (bus.out_valid !== 1'b1 || got !== want)
      $display("FAIL stall_release_load got v=%b %h want v=1 %h", bus.out_valid, got, want);
    else n_pass++;
    n_total++;
    if (bus.issue_cnt !== exp_cnt) $display("FAIL stall_release_cnt got %0d want %0d", bus.issue_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_flush();
    drive(1, 1'b1, 1'b1, 1'b1);
    tick();
    n_total++;
    if (bus.out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.issue_cnt !== exp_cnt) $display("FAIL flush_cnt got %0d want %0d", bus.issue_cnt, exp_cnt);
    else n_pass++;
    drive(5, 1'b1, 1'b1, 1'b0);
    tick();
    got  = {bus.alu_op, bus.alu_a, bus.alu_b, bus.dst_reg, bus.reg_wr, bus.illegal};
    want = {4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1};
    n_total++;
    if (bus.out_valid !== 1'b1 || got !== want)
      $display("FAIL flush_illegal got v=%b %h want v=1 %h", bus.out_valid, got, want);
    else n_pass++;
  endtask

  task automatic test_reset_inflight();
    int guard;
    rst = 1'b1;
    drive(0, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    guard = 0;
    while (exp_cnt < 7 && guard < 20) begin
      drive(guard % 16, 1'b1, 1'b1, 1'b0);
      tick();
      guard++;
    end
    n_total++;
    if (bus.issue_cnt !== 32'd7 || bus.out_valid !== 1'b1)
      $display("FAIL inflight_pre got cnt=%0d v=%b want cnt=7 v=1", bus.issue_cnt, bus.out_valid);
    else n_pass++;
    rst = 1'b1;
    drive(2, 1'b1, 1'b1, 1'b1);
    tick();
    got = {bus.alu_op, bus.alu_a, bus.alu_b, bus.dst_reg, bus.reg_wr, bus.illegal};
    n_total++;
    if (bus.out_valid !== 1'b0 || got !== 75'd0 || bus.issue_cnt !== 32'd0)
      $display("FAIL inflight_reset got v=%b %h cnt=%0d want all 0", bus.out_valid, got,
               bus.issue_cnt);
    else n_pass++;
    rst = 1'b0;
    drive(2, 1'b1, 1'b1, 1'b0);
    tick();
    got  = {bus.alu_op, bus.alu_a, bus.alu_b, bus.dst_reg, bus.reg_wr, bus.illegal};
    want = {4'd4, 32'h12, 32'h0000FFFF, 5'd2, 1'b1, 1'b0};
    n_total++;
    if (bus.out_valid !== 1'b1 || got !== want)
      $display("FAIL inflight_recover got v=%b %h want v=1 %h", bus.out_valid, got, want);
    else n_pass++;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    exp_valid = 1'b0;
    exp_cnt   = 0;
    rst       = 1'b1;
    init_table();
    drive(0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_add();
    test_decode();
    test_stall();
    test_flush();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst  in  1  synchronous active-high reset.
REQ-004 Port: in_valid  in  1  in_instr/rs_data/rt_data valid this cycle.
REQ-005 Port: in_ready  out  1  stage accepts input this cycle.
REQ-006 Port: in_instr  in  32  MIPS instruction word.
REQ-007 Port: rs_addr, rt_addr  out  5 each  combinational in_instr[25:21], in_instr[20:16] to the register file.
REQ-008 Port: rs_data, rt_data  in  32 each  register file read data for rs_addr/rt_addr, same cycle.
REQ-009 Port: flush  in  1  discard the held entry.
REQ-010 Port: out_valid  out  1  registered entry valid.
REQ-011 Port: out_ready  in  1  downstream consumes the entry.
REQ-012 Port: alu_a, alu_b  out  32 each  registered ALU operands.
REQ-013 Port: alu_op  out  4  registered ALU opcode: 0 zero, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 nor, 7 sltu, 8 slt, 9 lui, 10 shift-left, 11 shift-right-arith, 12 shift-right-logical (shift amount from alu_a[4:0], shifted value alu_b).
REQ-014 Port: dst_reg  out  5  registered destination register; reg_wr  out  1  registered write enable; illegal  out  1  registered unsupported-instruction flag.
REQ-015 Port: issue_cnt  out  32  count of entries consumed downstream.

Function
REQ-016 Decode: op=in_instr[31:26], funct=[5:0], shamt=[10:6], imm=[15:0]; sext=sign-extended imm, zext=zero-extended imm.
REQ-017 op=0 funct: 0x20/0x21->1, 0x22/0x23->2, 0x24->3, 0x25->4, 0x26->5, 0x27->6, 0x2A->8, 0x2B->7; a=rs_data, b=rt_data, dst=rd ([15:11]), reg_wr=1.
REQ-018 op=0 funct 0x00->10, 0x02->12, 0x03->11 with a={27'b0,shamt}; 0x04->10, 0x06->12, 0x07->11 with a=rs_data; all b=rt_data, dst=rd, reg_wr=1.
REQ-019 I-type: 0x08/0x09->1 sext; 0x0A->8 sext; 0x0B->7 sext; 0x0C->3 zext; 0x0D->4 zext; 0x0E->5 zext; 0x0F->9 b=zext; 0x23 (lw)->1 sext; all a=rs_data, dst=rt, reg_wr=1.
REQ-020 op=0x2B (sw)->1, a=rs_data, b=sext, dst=0, reg_wr=0.
REQ-021 Any other op/funct: alu_op=0, a=b=0, dst=0, reg_wr=0, illegal=1; illegal=0 for all decoded cases.
REQ-022 reg_wr SHALL be forced 0 when dst decodes to register 0.
REQ-023 in_ready = !out_valid || out_ready (combinational, single entry, no skid buffer).
REQ-024 Accept = in_valid && in_ready; on accept, all decoded fields load and out_valid=1 at next edge (latency 1 cycle).
REQ-025 out_valid && out_ready && !accept: out_valid clears next edge; payload registers hold.
REQ-026 Not accepting and out_ready=0: all output registers hold (stall).
REQ-027 issue_cnt increments by 1 each edge with out_valid && out_ready && !flush; wraps 0xFFFFFFFF->0.
REQ-028 flush=1: out_valid=0 next edge, input not accepted (in_ready irrelevant), issue_cnt not incremented; flush has priority over accept and consume.

Reset
REQ-029 rst=1 at an edge SHALL set out_valid, alu_a, alu_b, alu_op, dst_reg, reg_wr, illegal, issue_cnt to 0; rst overrides flush and accept; in-flight entry is discarded.

Verification
REQ-030 Reset then in_instr=0x01095020 (add $10,$8,$9), rs_data=5, rt_data=7, out_ready=1 -> next cycle out_valid=1, alu_op=1, a=5, b=7, dst=10, reg_wr=1; following cycle issue_cnt=1.
REQ-031 addi $2,$0,-1 (0x2002FFFF), rs_data=0 -> alu_op=1, b=0xFFFFFFFF, dst=2; ori (0x3402FFFF) -> alu_op=4, b=0x0000FFFF.
REQ-032 sll $3,$4,5 (0x00041940), rt_data=0x1 -> alu_op=10, a=5, b=1, dst=3; sw (0xAC040008) -> alu_op=1, b=8, reg_wr=0.
REQ-033 out_ready=0 with entry held, new in_valid -> in_ready=0, outputs unchanged 3 cycles; out_ready=1 -> new entry loaded same edge, issue_cnt +1.
REQ-034 Held entry, flush=1 with in_valid=1 -> out_valid=0, issue_cnt unchanged; undefined op 0x3F -> illegal=1, alu_op=0, reg_wr=0.
REQ-035 rst asserted with out_valid=1 and issue_cnt=7 -> all outputs 0 next edge.
